coin_acceptor: RTL and testbench

Front-end stage directly upstream of `coffee_machine`. It synchronises and debounces the three raw coin-sensor lines, rejects ambiguous or overflowing insertions, and queues accepted coins. Coins are replayed to the machine as mutually exclusive single-cycle pulses on `money_in025` / `money_in05` / `money_in1`, spaced so that no credit is lost. It also flags jammed sensors and keeps a running count of accepted coins.

---
 rtl/coin_pkg.sv | 23 ++
 rtl/coin_debounce.sv | 90 +++++++++
 rtl/coin_acceptor.sv | 130 +++++++++++++
 tb/tb_coin_acceptor.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared types and defaults for the coin acceptor front-end.
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'd0,
    COIN_025  = 2'd1,
    COIN_050  = 2'd2,
    COIN_100  = 2'd3
  } coin_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPressed = 2'd1,
    StJammed  = 2'd2
  } deb_state_e;

  localparam int unsigned DefDebounceCycles = 4;
  localparam int unsigned DefJamCycles      = 64;
  localparam int unsigned DefQueueDepth     = 4;
  localparam int unsigned NumChan           = 3;
  localparam int unsigned COUNT_W           = 10;

endpackage

// File: rtl/coin_debounce.sv
// One coin-sensor channel: 2-flop synchroniser, press/release debouncer and jam detection.
module coin_debounce
  import coin_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned JAM_CYCLES      = DefJamCycles
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic event_o,
  output logic jammed_o
);

  localparam int unsigned HoldW = $clog2(JAM_CYCLES);
  localparam logic [7:0] DebLast = 8'(DEBOUNCE_CYCLES - 1);
  // Hold counter reads 0 in the first cycle after the event, so JAMMED starts JAM_CYCLES later.
  localparam logic [HoldW-1:0] HoldLast = HoldW'(JAM_CYCLES - 2);

  deb_state_e       state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             synced;

  assign synced = sync_q[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      sync_q  <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    sync_d  = {sync_q[0], raw_i};
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        hold_d = '0;
        if (synced) begin
          if (cnt_q == DebLast) begin
            state_d = StPressed;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      StPressed, StJammed: begin
        if (!synced) begin
          if (cnt_q == DebLast) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          cnt_d = '0;
        end
        // A completed release wins over a jam reached in the same cycle.
        if (state_q == StPressed && state_d == StPressed) begin
          if (hold_q == HoldLast) begin
            state_d = StJammed;
          end else begin
            hold_d = hold_q + HoldW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    event_o  = (state_q == StIdle) && synced && (cnt_q == DebLast);
    jammed_o = (state_q == StJammed);
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounces three sensors, arbitrates insertions, queues coins and paces pulses.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned JAM_CYCLES      = DefJamCycles,
  parameter int unsigned QUEUE_DEPTH     = DefQueueDepth
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [2:0]         coin_raw,
  input  logic               accept_en,
  output logic               money_in025,
  output logic               money_in05,
  output logic               money_in1,
  output logic               coin_reject,
  output logic               jam,
  output logic [COUNT_W-1:0] accepted_count
);

  localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW = $clog2(QUEUE_DEPTH + 1);

  logic [NumChan-1:0] ev;
  logic [NumChan-1:0] jammed;

  for (genvar i = 0; i < NumChan; i++) begin : g_chan
    coin_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .JAM_CYCLES     (JAM_CYCLES)
    ) u_deb (
      .clock   (clock),
      .reset   (reset),
      .raw_i   (coin_raw[i]),
      .event_o (ev[i]),
      .jammed_o(jammed[i])
    );
  end

  coin_e              mem_q [QUEUE_DEPTH];
  coin_e              mem_d [QUEUE_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    fifo_cnt_q, fifo_cnt_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [2:0]         money_q, money_d;
  logic               reject_q, reject_d;
  logic               gap_q, gap_d;

  coin_e push_code;
  coin_e head;
  logic  full, empty, pop, push;

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q      <= '{default: COIN_NONE};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      count_q    <= '0;
      money_q    <= '0;
      reject_q   <= 1'b0;
      gap_q      <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      count_q    <= count_d;
      money_q    <= money_d;
      reject_q   <= reject_d;
      gap_q      <= gap_d;
    end
  end

  // Arbitration: only a lone event with no jam and a free (or freeing) slot is accepted.
  always_comb begin
    unique case (ev)
      3'b001:  push_code = COIN_025;
      3'b010:  push_code = COIN_050;
      3'b100:  push_code = COIN_100;
      default: push_code = COIN_NONE;
    endcase
    full     = (fifo_cnt_q == CntW'(QUEUE_DEPTH));
    empty    = (fifo_cnt_q == '0);
    pop      = !empty && accept_en && !gap_q;
    push     = (push_code != COIN_NONE) && !jam && (!full || pop);
    reject_d = (|ev) && !push;
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    count_d    = count_q;
    money_d    = '0;
    gap_d      = pop;
    head       = mem_q[rd_ptr_q];
    if (push) begin
      mem_d[wr_ptr_q] = push_code;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
      count_d         = count_q + COUNT_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case (head)
        COIN_025: money_d[0] = 1'b1;
        COIN_050: money_d[1] = 1'b1;
        COIN_100: money_d[2] = 1'b1;
        default:  money_d    = '0;
      endcase
    end
    unique case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CntW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CntW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_comb begin
    jam            = |jammed;
    money_in025    = money_q[0];
    money_in05     = money_q[1];
    money_in1      = money_q[2];
    coin_reject    = reject_q;
    accepted_count = count_q;
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with default parameters and hand-computed timing.
module tb_coin_acceptor;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] coin_raw;
  logic       accept_en;
  logic       money_in025, money_in05, money_in1, coin_reject, jam;
  logic [9:0] accepted_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n025 = 0, n05 = 0, n1 = 0, nrej = 0;
  int last025 = -1, last05 = -1, last1 = -1, lastrej = -1;
  int b025, b05, b1, brej;
  int t, a, r;

  coin_acceptor dut (
    .clock         (clock),
    .reset         (reset),
    .coin_raw      (coin_raw),
    .accept_en     (accept_en),
    .money_in025   (money_in025),
    .money_in05    (money_in05),
    .money_in1     (money_in1),
    .coin_reject   (coin_reject),
    .jam           (jam),
    .accepted_count(accepted_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (money_in025) begin n025++; last025 = cyc; end
    if (money_in05)  begin n05++;  last05  = cyc; end
    if (money_in1)   begin n1++;   last1   = cyc; end
    if (coin_reject) begin nrej++; lastrej = cyc; end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b025 = n025; b05 = n05; b1 = n1; brej = nrej;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic coin(input logic [2:0] bits, input int hold, input int gap);
    coin_raw = bits;
    tick(hold);
    coin_raw = 3'b000;
    tick(gap);
  endtask

  initial begin
    reset     = 1'b1;
    coin_raw  = 3'b000;
    accept_en = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("reset_money", {money_in025, money_in05, money_in1}, 0);
    check("reset_reject", coin_reject, 0);
    check("reset_jam", jam, 0);
    check("reset_count", accepted_count, 0);

    // Single 0.25 coin: pulse in cycle t + 7
    snap();
    coin_raw = 3'b001;
    t = cyc;
    tick(5);
    check("c025_count_before_push", accepted_count, 0);
    tick(1);
    check("c025_count_after_push", accepted_count, 1);
    check("c025_no_pulse_yet", money_in025, 0);
    tick(1);
    check("c025_pulse", money_in025, 1);
    tick(1);
    check("c025_pulse_one_cycle", money_in025, 0);
    tick(2);
    coin_raw = 3'b000;
    tick(20);
    check("c025_num_pulses", n025 - b025, 1);
    check("c025_pulse_cycle", last025, t + 7);
    check("c025_no_other_money", (n05 - b05) + (n1 - b1), 0);
    check("c025_no_reject", nrej - brej, 0);

    // Bounce on bit1 never reaches four consecutive ones
    do_reset();
    snap();
    coin_raw = 3'b010; tick(1);
    coin_raw = 3'b000; tick(1);
    coin_raw = 3'b010; tick(2);
    coin_raw = 3'b000; tick(20);
    check("bounce_no_pulse", n05 - b05, 0);
    check("bounce_no_reject", nrej - brej, 0);
    check("bounce_count", accepted_count, 0);

    // Two channels qualify together: single reject, nothing accepted
    do_reset();
    snap();
    t = cyc;
    coin(3'b110, 8, 20);
    check("dual_reject_count", nrej - brej, 1);
    check("dual_reject_cycle", lastrej, t + 6);
    check("dual_no_money", (n025 - b025) + (n05 - b05) + (n1 - b1), 0);
    check("dual_count", accepted_count, 0);

    // FIFO fill with downstream stalled, overflow reject, then drain
    do_reset();
    snap();
    accept_en = 1'b0;
    for (int k = 0; k < 5; k++) coin(3'b010, 6, 6);
    tick(10);
    check("fill_reject", nrej - brej, 1);
    check("fill_count", accepted_count, 4);
    check("fill_no_pulse", n05 - b05, 0);
    accept_en = 1'b1;
    a = cyc;
    tick(1);
    check("drain_first_pulse", money_in05, 1);
    tick(1);
    check("drain_gap", money_in05, 0);
    tick(12);
    check("drain_pulses", n05 - b05, 4);
    check("drain_last_cycle", last05, a + 7);
    check("drain_count", accepted_count, 4);

    // Held 1.00 coin jams, blocks a 0.25 insertion, then releases
    do_reset();
    snap();
    coin_raw = 3'b100;
    t = cyc;
    tick(68);
    check("jam_not_yet", jam, 0);
    tick(1);
    check("jam_rise", jam, 1);
    tick(1);
    coin_raw = 3'b101;
    tick(6);
    coin_raw = 3'b100;
    tick(4);
    coin_raw = 3'b000;
    r = cyc;
    tick(5);
    check("jam_still_high", jam, 1);
    tick(1);
    check("jam_fall", jam, 0);
    tick(15);
    check("jam_one_money1", n1 - b1, 1);
    check("jam_money1_cycle", last1, t + 7);
    check("jam_reject", nrej - brej, 1);
    check("jam_reject_cycle", lastrej, t + 76);
    check("jam_no_025", n025 - b025, 0);
    check("jam_count", accepted_count, 1);

    // Reset flushes queued coins without pulsing
    do_reset();
    snap();
    accept_en = 1'b0;
    for (int k = 0; k < 3; k++) coin(3'b001, 6, 6);
    check("flush_queued", accepted_count, 3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    accept_en = 1'b1;
    tick(12);
    check("flush_no_money", (n025 - b025) + (n05 - b05) + (n1 - b1), 0);
    check("flush_count", accepted_count, 0);
    check("flush_jam", jam, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
